// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_pkg
//  Brief    : Shared constants and types for the multiplexed 7-segment driver
//  Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Largest display this driver family supports
  localparam int MAX_DIGITS = 8;

  // All segments dark (active-low)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // No digit selected (active-low selects); slice to the display width
  localparam logic [MAX_DIGITS-1:0] SEL_NONE = {MAX_DIGITS{1'b1}};

  // Hex glyphs {dp,g,f,e,d,c,b,a}, active-low, dp dark; entry n = glyph n
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // What the output registers load in a given cycle
  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,   // display disabled
    PH_DEAD = 2'd1,   // anti-ghosting gap at the start of a slot
    PH_SHOW = 2'd2    // active digit driven
  } seg_phase_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_led_dynamic_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_led_dynamic_if
//  Brief    : Application-side and pin-side signals of the display driver
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_led_dynamic_if #(
  parameter int DIGITS = 6
);

  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  blank_lz;
  logic [DIGITS-1:0]     seg_sel;
  logic [7:0]            seg_led;
  logic                  frame_done;

  // Application / host side
  modport master (
    output en, load, data, dp, blank_lz,
    input  seg_sel, seg_led, frame_done
  );

  // Display driver side
  modport slave (
    input  en, load, data, dp, blank_lz,
    output seg_sel, seg_led, frame_done
  );

endinterface : seg_led_dynamic_if
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_hex_decoder
//  Brief    : Nibble + decimal point + blank -> active-low 7-segment code
//  Revision : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
  import seg_pkg::*;
(
  input  wire logic [3:0] i_nib,
  input  wire logic       i_dp,
  input  wire logic       i_blank,
  output logic      [7:0] o_seg
);

  // Glyph lookup; blanking darkens segments but leaves the dp alone
  always_comb begin
    o_seg = SEG_HEX[i_nib];
    if (i_blank) begin
      o_seg[6:0] = 7'h7F;
    end
    o_seg[7] = ~i_dp;
  end

endmodule : seg_hex_decoder
`default_nettype wire

// File: rtl/seg_led_dynamic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg_led_dynamic
//  Brief    : Time-multiplexed common-anode multi-digit 7-segment driver with
//             frame-coherent buffering, leading-zero blanking and dead time
//  Revision : 1.0 - initial release
// ============================================================================
module seg_led_dynamic
  import seg_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50_000,
  parameter int DEAD_CYC = 500
) (
  input  wire logic          sys_clk,
  input  wire logic          sys_rst,
  seg_led_dynamic_if.slave   bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  C_DEAD    = CNT_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]  C_IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] C_SEL_OFF = SEL_NONE[DIGITS-1:0];

  // Scan position
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;

  // Pending (written by load) and shadow (displayed) buffers
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [4*DIGITS-1:0] r_shadow_data;
  logic [DIGITS-1:0]   r_shadow_dp;

  // Registered pins
  logic [DIGITS-1:0]   r_seg_sel;
  logic [7:0]          r_seg_led;
  logic                r_frame_done;
  logic                r_wrap_d;

  logic                w_slot_end;
  logic                w_wrap;
  logic [DIGITS-1:0]   w_upper_zero;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [7:0]          w_seg_code;
  logic [DIGITS-1:0]   w_sel_show;
  seg_phase_t          w_phase;

  assign w_slot_end = (r_cnt == C_CNT_MAX);
  assign w_wrap     = w_slot_end && (r_idx == C_IDX_MAX) && bus.en;

  // w_upper_zero[i] is set when shadow nibbles i..DIGITS-1 are all zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    if (gi == DIGITS - 1) begin : g_top
      assign w_upper_zero[gi] = (r_shadow_data[4*gi +: 4] == 4'h0);
    end else begin : g_mid
      assign w_upper_zero[gi] = (r_shadow_data[4*gi +: 4] == 4'h0) && w_upper_zero[gi+1];
    end
  end

  // Current digit's content, taken only from the shadow so a frame never tears
  assign w_nib      = r_shadow_data[{r_idx, 2'b00} +: 4];
  assign w_dp       = r_shadow_dp[r_idx];
  assign w_blank    = bus.blank_lz && (r_idx != '0) && w_upper_zero[r_idx];
  assign w_sel_show = ~(DIGITS'(1) << r_idx);

  seg_hex_decoder u_dec (
    .i_nib   (w_nib),
    .i_dp    (w_dp),
    .i_blank (w_blank),
    .o_seg   (w_seg_code)
  );

  // Pick what the output registers load this cycle
  always_comb begin
    w_phase = PH_SHOW;
    if (!bus.en) begin
      w_phase = PH_OFF;
    end else if ((DEAD_CYC != 0) && (r_cnt < C_DEAD)) begin
      w_phase = PH_DEAD;
    end
  end

  // Slot counter and digit index; disabling parks the scan on digit 0, cycle 0
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!bus.en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == C_IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Load always captures into pend; shadow takes the pre-edge pend at a wrap
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pend_data   <= '0;
      r_pend_dp     <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
    end else begin
      if (bus.load) begin
        r_pend_data <= bus.data;
        r_pend_dp   <= bus.dp;
      end
      if (w_wrap) begin
        r_shadow_data <= r_pend_data;
        r_shadow_dp   <= r_pend_dp;
      end
    end
  end

  // Pin registers; frame_done lags the wrap by one so it coincides with the
  // first output cycle of digit 0 in the new frame
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_seg_sel    <= C_SEL_OFF;
      r_seg_led    <= SEG_OFF;
      r_wrap_d     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wrap_d     <= w_wrap;
      r_frame_done <= r_wrap_d && bus.en;
      case (w_phase)
        PH_SHOW: begin
          r_seg_sel <= w_sel_show;
          r_seg_led <= w_seg_code;
        end
        default: begin
          r_seg_sel <= C_SEL_OFF;
          r_seg_led <= SEG_OFF;
        end
      endcase
    end
  end

  assign bus.seg_sel    = r_seg_sel;
  assign bus.seg_led    = r_seg_led;
  assign bus.frame_done = r_frame_done;

endmodule : seg_led_dynamic
`default_nettype wire

// File: tb/tb_seg_led_dynamic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seg_led_dynamic
//  Brief    : Self-checking bench for seg_led_dynamic (6 digits, 8-cycle
//             slots, 2 dead cycles) against a frame-position reference model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_led_dynamic;

  localparam int DIGITS   = 6;
  localparam int SCAN_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  seg_led_dynamic_if #(.DIGITS(DIGITS)) bus ();

  seg_led_dynamic #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Glyph table written straight from the decode list
  logic [7:0] HEX_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] ref_seg(input int digit, input logic [23:0] d,
                                         input logic [5:0] dpv, input logic blz);
    logic [23:0] upper;
    logic [3:0]  nib;
    logic [7:0]  r;
    upper = d >> (4 * digit);
    nib   = upper[3:0];
    r     = HEX_TAB[nib];
    if (blz && digit > 0 && upper == 24'd0) r[6:0] = 7'h7F;
    r[7]  = ~dpv[digit];
    return r;
  endfunction

  // Reference model: p is the position within the frame (0..FRAME-1)
  int          p;
  logic [23:0] m_pend_d, m_shad_d;
  logic [5:0]  m_pend_dp, m_shad_dp;
  logic [5:0]  e_sel;
  logic [7:0]  e_led;
  logic        e_fd, m_fd_next;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p         <= 0;
      m_pend_d  <= '0;
      m_pend_dp <= '0;
      m_shad_d  <= '0;
      m_shad_dp <= '0;
      e_sel     <= 6'h3F;
      e_led     <= 8'hFF;
      e_fd      <= 1'b0;
      m_fd_next <= 1'b0;
    end else begin
      if (bus.en) begin
        if ((p % SCAN_DIV) < DEAD_CYC) begin
          e_sel <= 6'h3F;
          e_led <= 8'hFF;
        end else begin
          e_sel <= ~(6'd1 << (p / SCAN_DIV));
          e_led <= ref_seg(p / SCAN_DIV, m_shad_d, m_shad_dp, bus.blank_lz);
        end
        e_fd      <= m_fd_next;
        m_fd_next <= (p == FRAME - 1);
        if (p == FRAME - 1) begin
          p         <= 0;
          m_shad_d  <= m_pend_d;
          m_shad_dp <= m_pend_dp;
        end else begin
          p <= p + 1;
        end
      end else begin
        p         <= 0;
        e_sel     <= 6'h3F;
        e_led     <= 8'hFF;
        e_fd      <= 1'b0;
        m_fd_next <= 1'b0;
      end
      if (bus.load) begin
        m_pend_d  <= bus.data;
        m_pend_dp <= bus.dp;
      end
    end
  end

  // Compare pins against the model half a cycle after each active edge
  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("seg_sel",    32'(bus.seg_sel),    32'(e_sel));
      check("seg_led",    32'(bus.seg_led),    32'(e_led));
      check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] dpv);
    @(negedge sys_clk);
    bus.load = 1'b1;
    bus.data = d;
    bus.dp   = dpv;
    @(negedge sys_clk);
    bus.load = 1'b0;
  endtask

  // Returns at a falling edge where the model sits at frame position target
  task automatic wait_pos(input int target);
    int k;
    for (k = 0; k < 4 * FRAME; k++) begin
      @(negedge sys_clk);
      if (p == target) break;
    end
    if (k >= 4 * FRAME) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos timeout target=%0d actual=%0d", target, p);
    end
  endtask

  initial begin
    bus.en       = 1'b1;
    bus.load     = 1'b0;
    bus.data     = '0;
    bus.dp       = '0;
    bus.blank_lz = 1'b0;

    // Reset and idle scan showing zeros
    #2 sys_rst = 1'b1;
    #1;
    check("rst_sel", 32'(bus.seg_sel), 32'h3F);
    check("rst_led", 32'(bus.seg_led), 32'hFF);
    check("rst_fd",  32'(bus.frame_done), 32'h0);
    chk_en = 1'b1;
    run(3);
    #2 sys_rst = 1'b0;
    run(2 * FRAME + 4);

    // Mixed glyphs with a dp on digit 0
    do_load(24'h123ABF, 6'b000001);
    run(2 * FRAME);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(24'h000070, 6'b000000);
    run(2 * FRAME);
    do_load(24'h000000, 6'b000100);
    run(2 * FRAME);
    bus.blank_lz = 1'b0;

    // Load coinciding with the wrap edge
    do_load(24'h111111, 6'b000000);
    wait_pos(FRAME - 1);
    bus.load = 1'b1;
    bus.data = 24'hFFFFFF;
    bus.dp   = 6'b000000;
    @(negedge sys_clk);
    bus.load = 1'b0;
    run(2 * FRAME + 2);

    // Disable mid-frame, with a load while disabled
    wait_pos(20);
    bus.en = 1'b0;
    run(5);
    do_load(24'h456789, 6'b101010);
    run(13);
    bus.en = 1'b1;
    run(2 * FRAME + 3);

    // Asynchronous reset in the middle of digit 3's slot
    wait_pos(3 * SCAN_DIV + 4);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_sel", 32'(bus.seg_sel), 32'h3F);
    check("async_rst_led", 32'(bus.seg_led), 32'hFF);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    run(FRAME + 4);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge sys_clk);
      bus.load = ($urandom_range(0, 7) == 0);
      bus.data = 24'($urandom);
      bus.dp   = 6'($urandom);
      if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
      if (bus.en) begin
        if ($urandom_range(0, 149) == 0) bus.en = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.en = 1'b1;
      end
      if ($urandom_range(0, 599) == 0) begin
        #2 sys_rst = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
      end
    end
    bus.load = 1'b0;
    run(4);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg_led_dynamic
`default_nettype wire
